pagerank_mem_responder: RTL and testbench
=========================================

PAGERANK_MEM_RESPONDER -- requirements
Module: pagerank_mem_responder

Interface
REQ-001 Parameter nwords, default 256, storage depth in 32-bit words (power of two, 4..65536).
REQ-002 Parameter nbits, default 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 memreq0_msg  input  77  VC mem request (8,32,32): type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0].
REQ-006 memreq0_val  input  1  port-0 request valid.
REQ-007 memreq0_rdy  output  1  port-0 request ready.
REQ-008 memresp0_msg  output  47  VC mem response (8,32): type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0].
REQ-009 memresp0_val  output  1  port-0 response valid.
REQ-010 memresp0_rdy  input  1  port-0 response ready.
REQ-011 memreq1_msg/val/rdy, memresp1_msg/val/rdy: identical to port 0, independent handshakes.

Function
REQ-012 Transfer on any channel occurs on a clk edge with val=1 and rdy=1; msg shall be held stable while val=1 and rdy=0.
REQ-013 Word index = addr[log2(nwords)+1:2]; higher address bits and addr[1:0] ignored (addresses wrap modulo 4*nwords).
REQ-014 Type READ(0): response data = stored word as it was before the accepting edge.
REQ-015 Type WRITE(1) and INIT(2): stored word replaced by request data at the accepting edge; response data = 0.
REQ-016 Types 3..7: no storage update, response data = 0.
REQ-017 Response type, opaque and len copy the request; test = 0; len ignored for access width (always full word).
REQ-018 Each port owns a 2-entry response FIFO; accepted request pushes its response at the same edge, so memresp_val rises exactly 1 cycle after acceptance (latency 1).
REQ-019 memreq_rdy = 1 iff that port's FIFO holds fewer than 2 entries and reset is deasserted; no pop-to-push bypass when full.
REQ-020 memresp_val = 1 iff FIFO non-empty; memresp_msg = FIFO head; pop on response transfer.
REQ-021 Simultaneous push and pop on a port: count unchanged, order preserved; sustained throughput 1 request/cycle/port with memresp_rdy held 1.
REQ-022 Both ports write the same word in one cycle: port 0 data wins.
REQ-023 Read on one port and write to same word on the other in one cycle: read returns old data.
REQ-024 Responses per port are returned strictly in request order; ports never reorder against their own traffic.

Reset
REQ-025 While reset=0: memreq0_rdy=memreq1_rdy=0, memresp0_val=memresp1_val=0, FIFO counts and pointers 0, response msgs 0.
REQ-026 Reset asserted mid-operation discards all pending responses immediately; storage contents are not reset and are undefined until written.
REQ-027 First request acceptance possible on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package pagerank_mem_pkg holds message widths (77/47), field offsets, type constants READ/WRITE/INIT, and request/response structs.
REQ-029 One sub-module pagerank_mem_resp_queue (2-entry, 47-bit, val/rdy FIFO) instantiated once per port; storage array and write-priority logic in the top.

Verification
REQ-030 Port 0 WRITE addr 0x10 data 0xDEADBEEF opaque 0x05, then READ 0x10 opaque 0x06 -> responses (WRITE,0x05,data 0) then (READ,0x06,0xDEADBEEF), each 1 cycle after acceptance.
REQ-031 Same-cycle WRITE addr 0x20 port0 data 0x1111, port1 data 0x2222, then READ 0x20 -> 0x00001111.
REQ-032 memresp0_rdy=0, three back-to-back port-0 READs -> two accepted, memreq0_rdy=0 on third; raise rdy -> third accepted, responses in order.
REQ-033 Port 1 WRITE 0x44 data 0xA5A5A5A5, READ addr 0x44+4*nwords -> returns 0xA5A5A5A5 (wrap).
REQ-034 Two responses queued on both ports, reset=0 for one cycle asynchronously -> both val drop without clock edge; after release rdy=1, no stale responses.
REQ-035 Random 1000-request mixed traffic on both ports with random memresp_rdy, checked against a reference word array -> all data/opaque/order match.

Source files
------------

// File: rtl/pagerank_mem_pkg.sv
// Shared message layout, type codes and pack/unpack helpers for the
// PageRank memory responder and its response queue.
package pagerank_mem_pkg;

    localparam int REQ_W  = 77;
    localparam int RESP_W = 47;

    // Request field offsets (LSB of each field)
    localparam int REQ_TYPE_LSB = 74;
    localparam int REQ_OPQ_LSB  = 66;
    localparam int REQ_ADDR_LSB = 34;
    localparam int REQ_LEN_LSB  = 32;
    localparam int REQ_DATA_LSB = 0;

    // Response field offsets (LSB of each field)
    localparam int RESP_TYPE_LSB = 44;
    localparam int RESP_OPQ_LSB  = 36;
    localparam int RESP_TEST_LSB = 34;
    localparam int RESP_LEN_LSB  = 32;
    localparam int RESP_DATA_LSB = 0;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;
    localparam logic [2:0] MEM_INIT  = 3'd2;

    typedef struct packed {
        logic [2:0]  mtype;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        logic [2:0]  mtype;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_t;

    function automatic mem_req_t unpack_req(input logic [REQ_W-1:0] m);
        mem_req_t r;
        r.mtype  = m[REQ_TYPE_LSB +: 3];
        r.opaque = m[REQ_OPQ_LSB  +: 8];
        r.addr   = m[REQ_ADDR_LSB +: 32];
        r.len    = m[REQ_LEN_LSB  +: 2];
        r.data   = m[REQ_DATA_LSB +: 32];
        return r;
    endfunction

    function automatic logic [RESP_W-1:0] pack_resp(input mem_resp_t r);
        logic [RESP_W-1:0] m;
        m = '0;
        m[RESP_TYPE_LSB +: 3]  = r.mtype;
        m[RESP_OPQ_LSB  +: 8]  = r.opaque;
        m[RESP_TEST_LSB +: 2]  = r.test;
        m[RESP_LEN_LSB  +: 2]  = r.len;
        m[RESP_DATA_LSB +: 32] = r.data;
        return m;
    endfunction

    // WRITE and INIT both replace the addressed word
    function automatic logic is_store(input logic [2:0] t);
        return (t == MEM_WRITE) || (t == MEM_INIT);
    endfunction

endpackage

// File: rtl/pagerank_mem_resp_queue.sv
// Two-entry val/rdy response FIFO. No pop-to-push bypass: a full queue
// refuses new entries even when its head is leaving on the same edge.
module pagerank_mem_resp_queue
    import pagerank_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RESP_W-1:0] enq_msg,
    input  logic              enq_val,
    output logic              enq_rdy,
    output logic [RESP_W-1:0] deq_msg,
    output logic              deq_val,
    input  logic              deq_rdy
);

    logic [RESP_W-1:0] entry_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              push;
    logic              pop;

    assign enq_rdy = reset && (count_reg != 2'd2);
    assign deq_val = (count_reg != 2'd0);
    assign deq_msg = entry_reg[rd_ptr_reg];
    assign push    = enq_val && enq_rdy;
    assign pop     = deq_val && deq_rdy;

    // Entry storage, pointers and occupancy; reset discards everything at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                entry_reg[wr_ptr_reg] <= enq_msg;
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pagerank_mem_responder.sv
// Dual-port word memory answering VC mem requests with one-cycle latency.
// Reads see the word as it was before the accepting edge; when both ports
// store to the same word in one cycle, port 0 wins.
module pagerank_mem_responder
    import pagerank_mem_pkg::*;
#(
    parameter int nwords = 256,
    parameter int nbits  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  memreq0_msg,
    input  logic              memreq0_val,
    output logic              memreq0_rdy,
    output logic [RESP_W-1:0] memresp0_msg,
    output logic              memresp0_val,
    input  logic              memresp0_rdy,
    input  logic [REQ_W-1:0]  memreq1_msg,
    input  logic              memreq1_val,
    output logic              memreq1_rdy,
    output logic [RESP_W-1:0] memresp1_msg,
    output logic              memresp1_val,
    input  logic              memresp1_rdy
);

    localparam int IDXW = $clog2(nwords);

    logic [nbits-1:0]  mem [nwords];

    logic [REQ_W-1:0]  req_msg  [2];
    logic [1:0]        req_val;
    logic [1:0]        req_rdy;
    logic [RESP_W-1:0] resp_msg [2];
    logic [1:0]        resp_val;
    logic [1:0]        resp_rdy;

    logic [1:0]        wen;
    logic [IDXW-1:0]   widx  [2];
    logic [nbits-1:0]  wdata [2];

    assign req_msg[0]   = memreq0_msg;
    assign req_msg[1]   = memreq1_msg;
    assign req_val      = {memreq1_val, memreq0_val};
    assign resp_rdy     = {memresp1_rdy, memresp0_rdy};
    assign memreq0_rdy  = req_rdy[0];
    assign memreq1_rdy  = req_rdy[1];
    assign memresp0_msg = resp_msg[0];
    assign memresp1_msg = resp_msg[1];
    assign memresp0_val = resp_val[0];
    assign memresp1_val = resp_val[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            mem_req_t          req;
            mem_resp_t         resp;
            logic [IDXW-1:0]   idx;
            logic              unused_addr_bits;

            assign req = unpack_req(req_msg[gi]);
            // Addresses wrap: only the word-index bits select storage
            assign idx = req.addr[IDXW+1:2];
            assign unused_addr_bits = ^{req.addr[31:IDXW+2], req.addr[1:0]};

            // Build the response pushed into this port's queue on acceptance
            always_comb begin
                resp        = '0;
                resp.mtype  = req.mtype;
                resp.opaque = req.opaque;
                resp.test   = 2'b00;
                resp.len    = req.len;
                resp.data   = (req.mtype == MEM_READ) ? mem[idx] : '0;
            end

            assign wen[gi]   = req_val[gi] && req_rdy[gi] && is_store(req.mtype);
            assign widx[gi]  = idx;
            assign wdata[gi] = req.data;

            pagerank_mem_resp_queue u_queue (
                .clk     (clk),
                .reset   (reset),
                .enq_msg (pack_resp(resp)),
                .enq_val (req_val[gi]),
                .enq_rdy (req_rdy[gi]),
                .deq_msg (resp_msg[gi]),
                .deq_val (resp_val[gi]),
                .deq_rdy (resp_rdy[gi])
            );
        end
    endgenerate

    // Storage update; port 1 goes first so a same-word port-0 store overrides it
    always_ff @(posedge clk) begin
        if (wen[1]) begin
            mem[widx[1]] <= wdata[1];
        end
        if (wen[0]) begin
            mem[widx[0]] <= wdata[0];
        end
    end

endmodule

// File: tb/tb_pagerank_mem_responder.sv
// Scoreboard bench for pagerank_mem_responder: the driver pushes expected
// responses on acceptance, a monitor pops and compares on each response transfer.
module tb_pagerank_mem_responder;

    localparam int NWORDS = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [76:0] memreq0_msg = '0;
    logic        memreq0_val = 1'b0;
    logic        memreq0_rdy;
    logic [46:0] memresp0_msg;
    logic        memresp0_val;
    logic        memresp0_rdy = 1'b0;
    logic [76:0] memreq1_msg = '0;
    logic        memreq1_val = 1'b0;
    logic        memreq1_rdy;
    logic [46:0] memresp1_msg;
    logic        memresp1_val;
    logic        memresp1_rdy = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [46:0] exp0 [$];
    logic [46:0] exp1 [$];
    logic [31:0] model [NWORDS];

    pagerank_mem_responder #(.nwords(NWORDS), .nbits(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .memreq0_msg  (memreq0_msg),
        .memreq0_val  (memreq0_val),
        .memreq0_rdy  (memreq0_rdy),
        .memresp0_msg (memresp0_msg),
        .memresp0_val (memresp0_val),
        .memresp0_rdy (memresp0_rdy),
        .memreq1_msg  (memreq1_msg),
        .memreq1_val  (memreq1_val),
        .memreq1_rdy  (memreq1_rdy),
        .memresp1_msg (memresp1_msg),
        .memresp1_val (memresp1_val),
        .memresp1_rdy (memresp1_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] opq,
                                           input logic [31:0] addr, input logic [1:0] len,
                                           input logic [31:0] data);
        return {t, opq, addr, len, data};
    endfunction

    function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] opq,
                                            input logic [1:0] len, input logic [31:0] data);
        return {t, opq, 2'b00, len, data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock of stimulus on both ports; expected responses are queued on acceptance
    task automatic step(input logic v0, input logic [76:0] m0, input logic [46:0] e0,
                        input logic v1, input logic [76:0] m1, input logic [46:0] e1,
                        output logic a0, output logic a1);
        memreq0_val = v0;
        memreq0_msg = m0;
        memreq1_val = v1;
        memreq1_msg = m1;
        @(negedge clk);
        a0 = v0 && memreq0_rdy;
        a1 = v1 && memreq1_rdy;
        if (a0) exp0.push_back(e0);
        if (a1) exp1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a0, a1;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, a0, a1);
    endtask

    function automatic logic [46:0] model_resp(input logic [76:0] m);
        logic [31:0] addr;
        logic [2:0]  t;
        addr = m[65:34];
        t    = m[76:74];
        return {t, m[73:66], 2'b00, m[33:32], (t == 3'd0) ? model[addr[9:2]] : 32'h0};
    endfunction

    task automatic model_apply(input logic [76:0] m);
        logic [31:0] addr;
        addr = m[65:34];
        if (m[76:74] == 3'd1 || m[76:74] == 3'd2) model[addr[9:2]] = m[31:0];
    endtask

    function automatic logic [76:0] rand_req();
        int r;
        logic [2:0]  t;
        logic [31:0] addr;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        if (r < 4)      t = 3'd0;
        else if (r < 7) t = 3'd1;
        else if (r < 8) t = 3'd2;
        else            t = 3'($urandom_range(3, 7));
        w    = $urandom_range(0, 7);
        addr = ($urandom() & 32'hFFFF_FC03) | (w << 2);
        return mk_req(t, 8'($urandom()), addr, 2'($urandom()), $urandom());
    endfunction

    // Monitor: compare every response transfer against the scoreboard head
    always @(negedge clk) begin
        if (reset && memresp0_val && memresp0_rdy) begin
            if (exp0.size() == 0) begin
                total++; bad++;
                $display("FAIL p0_unexpected: got %h want none", memresp0_msg);
            end else begin
                chk("p0_resp", {17'h0, memresp0_msg}, {17'h0, exp0.pop_front()});
            end
        end
        if (reset && memresp1_val && memresp1_rdy) begin
            if (exp1.size() == 0) begin
                total++; bad++;
                $display("FAIL p1_unexpected: got %h want none", memresp1_msg);
            end else begin
                chk("p1_resp", {17'h0, memresp1_msg}, {17'h0, exp1.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic a0, a1;
        logic [76:0] pm0, pm1;
        logic pv0, pv1;
        int tries, sent;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", {62'h0, memreq1_rdy, memreq0_rdy}, 64'h0);
        chk("rst_resp_val", {62'h0, memresp1_val, memresp0_val}, 64'h0);
        chk("rst_resp_msg0", {17'h0, memresp0_msg}, 64'h0);
        chk("rst_resp_msg1", {17'h0, memresp1_msg}, 64'h0);

        memresp0_rdy = 1'b1;
        memresp1_rdy = 1'b1;
        reset = 1'b1;

        // WRITE then READ on port 0, first edge after release accepts, latency 1
        step(1'b1, mk_req(3'd1, 8'h05, 32'h10, 2'd0, 32'hDEADBEEF), mk_resp(3'd1, 8'h05, 2'd0, 32'h0),
             1'b0, '0, '0, a0, a1);
        chk("first_accept", {63'h0, a0}, 64'h1);
        chk("lat_write", {63'h0, memresp0_val}, 64'h1);
        step(1'b1, mk_req(3'd0, 8'h06, 32'h10, 2'd0, 32'h0), mk_resp(3'd0, 8'h06, 2'd0, 32'hDEADBEEF),
             1'b0, '0, '0, a0, a1);
        chk("lat_read", {63'h0, memresp0_val}, 64'h1);
        idle(1);
        chk("idle_val", {63'h0, memresp0_val}, 64'h0);

        // Same-cycle writes to one word: port 0 wins
        step(1'b1, mk_req(3'd1, 8'h07, 32'h20, 2'd0, 32'h1111), mk_resp(3'd1, 8'h07, 2'd0, 32'h0),
             1'b1, mk_req(3'd1, 8'h08, 32'h20, 2'd0, 32'h2222), mk_resp(3'd1, 8'h08, 2'd0, 32'h0), a0, a1);
        step(1'b1, mk_req(3'd0, 8'h09, 32'h20, 2'd0, 32'h0), mk_resp(3'd0, 8'h09, 2'd0, 32'h1111),
             1'b1, mk_req(3'd0, 8'h0A, 32'h20, 2'd1, 32'h0), mk_resp(3'd0, 8'h0A, 2'd1, 32'h1111), a0, a1);
        // Read on one port while the other writes the same word: old data
        step(1'b1, mk_req(3'd0, 8'h0B, 32'h20, 2'd0, 32'h0), mk_resp(3'd0, 8'h0B, 2'd0, 32'h1111),
             1'b1, mk_req(3'd1, 8'h0C, 32'h20, 2'd3, 32'h3333), mk_resp(3'd1, 8'h0C, 2'd3, 32'h0), a0, a1);
        step(1'b1, mk_req(3'd0, 8'h0D, 32'h20, 2'd0, 32'h0), mk_resp(3'd0, 8'h0D, 2'd0, 32'h3333),
             1'b1, mk_req(3'd2, 8'h0E, 32'h24, 2'd0, 32'h7777), mk_resp(3'd2, 8'h0E, 2'd0, 32'h0), a0, a1);
        // Type 5 neither stores nor returns data
        step(1'b0, '0, '0,
             1'b1, mk_req(3'd5, 8'h0F, 32'h24, 2'd2, 32'hFFFF), mk_resp(3'd5, 8'h0F, 2'd2, 32'h0), a0, a1);
        step(1'b0, '0, '0,
             1'b1, mk_req(3'd0, 8'h10, 32'h24, 2'd0, 32'h0), mk_resp(3'd0, 8'h10, 2'd0, 32'h7777), a0, a1);
        idle(2);

        // Back-pressure: two fill the queue, third waits, no bypass on pop
        memresp0_rdy = 1'b0;
        step(1'b1, mk_req(3'd0, 8'h01, 32'h10, 2'd0, 32'h0), mk_resp(3'd0, 8'h01, 2'd0, 32'hDEADBEEF),
             1'b0, '0, '0, a0, a1);
        chk("bp_acc1", {63'h0, a0}, 64'h1);
        step(1'b1, mk_req(3'd0, 8'h02, 32'h20, 2'd0, 32'h0), mk_resp(3'd0, 8'h02, 2'd0, 32'h3333),
             1'b0, '0, '0, a0, a1);
        chk("bp_acc2", {63'h0, a0}, 64'h1);
        step(1'b1, mk_req(3'd0, 8'h03, 32'h10, 2'd0, 32'h0), mk_resp(3'd0, 8'h03, 2'd0, 32'hDEADBEEF),
             1'b0, '0, '0, a0, a1);
        chk("bp_acc3_blocked", {63'h0, a0}, 64'h0);
        chk("bp_rdy_low", {63'h0, memreq0_rdy}, 64'h0);
        memresp0_rdy = 1'b1;
        tries = 0;
        a0 = 1'b0;
        while (!a0 && tries < 6) begin
            step(1'b1, mk_req(3'd0, 8'h03, 32'h10, 2'd0, 32'h0), mk_resp(3'd0, 8'h03, 2'd0, 32'hDEADBEEF),
                 1'b0, '0, '0, a0, a1);
            tries++;
        end
        chk("bp_tries", 64'(tries), 64'd2);
        idle(3);

        // Address wrap on port 1
        step(1'b0, '0, '0,
             1'b1, mk_req(3'd1, 8'h21, 32'h44, 2'd0, 32'hA5A5A5A5), mk_resp(3'd1, 8'h21, 2'd0, 32'h0), a0, a1);
        step(1'b0, '0, '0,
             1'b1, mk_req(3'd0, 8'h22, 32'h44 + 4 * NWORDS, 2'd0, 32'h0), mk_resp(3'd0, 8'h22, 2'd0, 32'hA5A5A5A5),
             a0, a1);
        idle(2);

        // Mid-operation asynchronous reset discards queued responses
        memresp0_rdy = 1'b0;
        memresp1_rdy = 1'b0;
        step(1'b1, mk_req(3'd0, 8'h31, 32'h10, 2'd0, 32'h0), mk_resp(3'd0, 8'h31, 2'd0, 32'hDEADBEEF),
             1'b1, mk_req(3'd0, 8'h41, 32'h44, 2'd0, 32'h0), mk_resp(3'd0, 8'h41, 2'd0, 32'hA5A5A5A5), a0, a1);
        step(1'b1, mk_req(3'd0, 8'h32, 32'h10, 2'd0, 32'h0), mk_resp(3'd0, 8'h32, 2'd0, 32'hDEADBEEF),
             1'b1, mk_req(3'd0, 8'h42, 32'h44, 2'd0, 32'h0), mk_resp(3'd0, 8'h42, 2'd0, 32'hA5A5A5A5), a0, a1);
        memreq0_val = 1'b0;
        memreq1_val = 1'b0;
        chk("pre_rst_val", {62'h0, memresp1_val, memresp0_val}, 64'h3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_val", {62'h0, memresp1_val, memresp0_val}, 64'h0);
        chk("async_rst_rdy", {62'h0, memreq1_rdy, memreq0_rdy}, 64'h0);
        chk("async_rst_msg", {17'h0, memresp0_msg | memresp1_msg}, 64'h0);
        exp0.delete();
        exp1.delete();
        memresp0_rdy = 1'b1;
        memresp1_rdy = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);
        chk("no_stale", {62'h0, memresp1_val, memresp0_val}, 64'h0);

        // Known contents for the random-traffic words
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mk_req(3'd2, 8'(i), 32'(i * 4), 2'd0, 32'hC0DE0000 + 32'(i)),
                 mk_resp(3'd2, 8'(i), 2'd0, 32'h0), 1'b0, '0, '0, a0, a1);
            model[i] = 32'hC0DE0000 + 32'(i);
        end

        // Random mixed traffic checked against the reference word array
        pv0 = 1'b0;
        pv1 = 1'b0;
        pm0 = '0;
        pm1 = '0;
        sent = 0;
        for (int c = 0; c < 5000 && sent < 1000; c++) begin
            if (!pv0 && $urandom_range(0, 3) != 0) begin pm0 = rand_req(); pv0 = 1'b1; end
            if (!pv1 && $urandom_range(0, 3) != 0) begin pm1 = rand_req(); pv1 = 1'b1; end
            memresp0_rdy = 1'($urandom_range(0, 1));
            memresp1_rdy = 1'($urandom_range(0, 1));
            step(pv0, pm0, model_resp(pm0), pv1, pm1, model_resp(pm1), a0, a1);
            if (a1) model_apply(pm1);
            if (a0) model_apply(pm0);
            if (a0) begin pv0 = 1'b0; sent++; end
            if (a1) begin pv1 = 1'b0; sent++; end
        end
        chk("rand_sent", 64'(sent), 64'd1000);

        memresp0_rdy = 1'b1;
        memresp1_rdy = 1'b1;
        for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) idle(1);
        chk("drain_p0", 64'(exp0.size()), 64'd0);
        chk("drain_p1", 64'(exp1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
